// File: rtl/lsu_dbus_initiator_if.sv
// Data-bus request/acknowledge channel between a load/store initiator and its responder.
interface lsu_dbus_initiator_if #(
  parameter int unsigned XLEN = 32
);
  logic            dbus_req_o;
  logic            dbus_w_en_o;
  logic [XLEN-1:0] dbus_addr_o;
  logic [XLEN-1:0] dbus_w_data_o;
  logic [3:0]      dbus_sel_byte_o;
  logic [XLEN-1:0] dbus_r_data_i;
  logic            dbus_ack_i;

  modport master (
    output dbus_req_o,
    output dbus_w_en_o,
    output dbus_addr_o,
    output dbus_w_data_o,
    output dbus_sel_byte_o,
    input  dbus_r_data_i,
    input  dbus_ack_i
  );

  modport slave (
    input  dbus_req_o,
    input  dbus_w_en_o,
    input  dbus_addr_o,
    input  dbus_w_data_o,
    input  dbus_sel_byte_o,
    output dbus_r_data_i,
    output dbus_ack_i
  );
endinterface

// File: rtl/lsu_dbus_initiator.sv
// Load/store initiator: checks alignment, formats lanes, runs one dbus req/ack transaction
// per execute request, extracts/extends load data and times out a silent responder.
module lsu_dbus_initiator #(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 lsu_req_i,
  input  logic                 lsu_we_i,
  input  logic [2:0]           lsu_op_i,
  input  logic [XLEN-1:0]      lsu_addr_i,
  input  logic [XLEN-1:0]      lsu_wdata_i,
  output logic                 lsu_stall_o,
  output logic                 lsu_done_o,
  output logic [XLEN-1:0]      lsu_rdata_o,
  output logic                 lsu_misalign_o,
  output logic                 lsu_bus_err_o,
  lsu_dbus_initiator_if.master dbus
);

  typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;

  localparam logic [7:0] CntLast = 8'(TIMEOUT_CYCLES - 1);

  state_e          state_q;
  logic [7:0]      cnt_q;
  logic            we_q;
  logic [2:0]      op_q;
  logic [1:0]      addr_lo_q;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] w_data_q;
  logic [3:0]      sel_q;
  logic            done_q;
  logic            misalign_q;
  logic            bus_err_q;
  logic [XLEN-1:0] rdata_q;

  logic            req_bad;
  logic [3:0]      req_sel;
  logic [XLEN-1:0] req_wdata;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [XLEN-1:0] ld_val;

  // Request decode: illegal funct3 and misalignment both end as a misalign pulse.
  always_comb begin
    req_bad   = 1'b0;
    req_sel   = 4'b0000;
    req_wdata = lsu_wdata_i;
    case (lsu_op_i)
      3'b000, 3'b100: begin
        req_sel   = 4'b0001 << lsu_addr_i[1:0];
        req_wdata = {4{lsu_wdata_i[7:0]}};
        req_bad   = lsu_we_i & lsu_op_i[2];
      end
      3'b001, 3'b101: begin
        req_sel   = lsu_addr_i[1] ? 4'b1100 : 4'b0011;
        req_wdata = {2{lsu_wdata_i[15:0]}};
        req_bad   = lsu_addr_i[0] | (lsu_we_i & lsu_op_i[2]);
      end
      3'b010: begin
        req_sel = 4'b1111;
        req_bad = |lsu_addr_i[1:0];
      end
      default: req_bad = 1'b1;
    endcase
  end

  // Load extraction from the returned word; op_q[2] selects zero extension.
  always_comb begin
    ld_byte = dbus.dbus_r_data_i[7:0];
    case (addr_lo_q)
      2'd1:    ld_byte = dbus.dbus_r_data_i[15:8];
      2'd2:    ld_byte = dbus.dbus_r_data_i[23:16];
      2'd3:    ld_byte = dbus.dbus_r_data_i[31:24];
      default: ld_byte = dbus.dbus_r_data_i[7:0];
    endcase
    ld_half = addr_lo_q[1] ? dbus.dbus_r_data_i[31:16] : dbus.dbus_r_data_i[15:0];
    case (op_q[1:0])
      2'b00:   ld_val = {{24{ld_byte[7] & ~op_q[2]}}, ld_byte};
      2'b01:   ld_val = {{16{ld_half[15] & ~op_q[2]}}, ld_half};
      default: ld_val = dbus.dbus_r_data_i;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      we_q       <= 1'b0;
      op_q       <= '0;
      addr_lo_q  <= '0;
      addr_q     <= '0;
      w_data_q   <= '0;
      sel_q      <= '0;
      done_q     <= 1'b0;
      misalign_q <= 1'b0;
      bus_err_q  <= 1'b0;
      rdata_q    <= '0;
    end else begin
      done_q     <= 1'b0;
      misalign_q <= 1'b0;
      bus_err_q  <= 1'b0;
      rdata_q    <= '0;
      case (state_q)
        StIdle: begin
          if (lsu_req_i) begin
            if (req_bad) begin
              done_q     <= 1'b1;
              misalign_q <= 1'b1;
              state_q    <= StDone;
            end else begin
              we_q      <= lsu_we_i;
              op_q      <= lsu_op_i;
              addr_lo_q <= lsu_addr_i[1:0];
              addr_q    <= {lsu_addr_i[XLEN-1:2], 2'b00};
              w_data_q  <= req_wdata;
              sel_q     <= req_sel;
              cnt_q     <= '0;
              state_q   <= StReq;
            end
          end
        end
        StReq: begin
          if (dbus.dbus_ack_i) begin
            if (!we_q) rdata_q <= ld_val;
            done_q  <= 1'b1;
            state_q <= StDone;
          end else if (cnt_q == CntLast) begin
            done_q    <= 1'b1;
            bus_err_q <= 1'b1;
            state_q   <= StDone;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  // Request drops in the ack cycle so the responder never sees a second request.
  assign dbus.dbus_req_o      = (state_q == StReq) & ~dbus.dbus_ack_i;
  assign dbus.dbus_w_en_o     = we_q;
  assign dbus.dbus_addr_o     = addr_q;
  assign dbus.dbus_w_data_o   = w_data_q;
  assign dbus.dbus_sel_byte_o = sel_q;

  assign lsu_stall_o    = ((state_q == StIdle) & lsu_req_i) | (state_q == StReq);
  assign lsu_done_o     = done_q;
  assign lsu_rdata_o    = rdata_q;
  assign lsu_misalign_o = misalign_q;
  assign lsu_bus_err_o  = bus_err_q;

endmodule

// File: doc/lsu_dbus_initiator.md
# lsu_dbus_initiator

Load/store initiator for the data bus: accepts one load or store per request from the execute stage and issues a single request/acknowledge transaction to the data memory or peripheral bus. It owns all execute-side handling of a data access:
- alignment checks
- word-aligned addressing
- byte-lane select and write-data replication
- load extraction with sign/zero extension
- pipeline stall
- a no-ack timeout

It sits between execute and the `dbus` fabric, on the initiator side of the same `req`/`ack` interface that the data memory responds on.

## Interface
- `XLEN`, 32, data/address width (only 32 supported)
- `TIMEOUT_CYCLES`, 255, cycles in `REQ` without `dbus_ack_i` before bus error; range 2..255
- `clk`  in  1  clock
- `rst_n`  in  1  reset, synchronous, active-low
- `lsu_req_i`  in  1  execute presents a memory op; held until `lsu_done_o`
- `lsu_we_i`  in  1  1 = store, 0 = load
- `lsu_op_i`  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- `lsu_addr_i`  in  32  byte address
- `lsu_wdata_i`  in  32  store data (LSBs significant)
- `lsu_stall_o`  out  1  hold execute/earlier stages
- `lsu_done_o`  out  1  one-cycle completion pulse
- `lsu_rdata_o`  out  32  extended load result, valid with `lsu_done_o`
- `lsu_misalign_o`  out  1  one-cycle pulse: misaligned or illegal op, no bus access
- `lsu_bus_err_o`  out  1  one-cycle pulse with `lsu_done_o` on timeout
- `dbus_req_o`  out  1  bus request
- `dbus_w_en_o`  out  1  bus write enable
- `dbus_addr_o`  out  32  word-aligned address, bits [1:0] = 00
- `dbus_w_data_o`  out  32  lane-replicated write data
- `dbus_sel_byte_o`  out  4  byte lanes
- `dbus_r_data_i`  in  32  read word
- `dbus_ack_i`  in  1  responder acknowledge, arrives ≥1 cycle after `req` sampled

## Operation
- States: `IDLE`, `REQ`, `DONE`.
- **`IDLE`**:
  - On `lsu_req_i` with a legal aligned op:
    - latch `we`, `op`, `addr`, the formatted `w_data` and `sel_byte`
    - clear the timeout counter
    - go to `REQ`
  - On an illegal or misaligned op:
    - pulse `lsu_misalign_o` next cycle and go to `DONE`
    - no bus activity
- **Illegal ops:** `op` 011, 110 or 111; store with `op` 100 or 101.
- **Misaligned:** H/HU with `addr[0]`=1; W with `addr[1:0]`≠00.
- **`sel_byte`:**
  - B/BU: 0001<<`addr[1:0]`
  - H/HU: `addr[1]` ? 1100 : 0011
  - W: 1111
- **`w_data`:** SB {4{`wdata[7:0]`}}, SH {2{`wdata[15:0]`}}, SW `wdata`.
- **`REQ`**:
  - `dbus_req_o` = !`dbus_ack_i`. Combinational drop, so the responder never samples a second request.
  - Bus address, `w_en`, `w_data` and `sel_byte` are stable throughout `REQ`.
  - On `dbus_ack_i`:
    - load: capture the extracted result
    - go to `DONE`
  - Otherwise increment the counter. At `TIMEOUT_CYCLES` set the error flag, force rdata to 0 and go to `DONE`.
- **Load extraction:**
  - Byte = `r_data` lane `addr[1:0]`; half = `addr[1]` ? [31:16] : [15:0].
  - B/H sign-extend; BU/HU zero-extend.
- **`DONE`**:
  - `lsu_done_o`=1.
  - `lsu_rdata_o` holds the result; it is 0 for stores, errors and misaligned ops.
  - `lsu_misalign_o` or `lsu_bus_err_o` is asserted as flagged.
  - Always return to `IDLE` next cycle. `lsu_req_i` is ignored in `DONE`.
- **`lsu_stall_o`** = (`IDLE` & `lsu_req_i`) | `REQ`. It is 0 in `DONE`.
- **Spurious `dbus_ack_i`** in `IDLE` or `DONE` is ignored.
- **Late ack after timeout:** ignored, since the initiator is no longer in `REQ`.

## Timing
- **Reset:**
  - state `IDLE`, counter 0
  - all outputs 0: `dbus_req_o`, `dbus_w_en_o`, `dbus_addr_o`, `dbus_w_data_o`, `dbus_sel_byte_o`, `lsu_done_o`, `lsu_rdata_o`, `lsu_misalign_o`, `lsu_bus_err_o`
  - `lsu_stall_o` follows its equation and is therefore 0 while `lsu_req_i`=0
- **Reset mid-transaction:** `REQ` is abandoned, `dbus_req_o`=0 the cycle after reset is sampled, and no done pulse is produced.
- **Single-cycle-ack responder:**
  - C0: `lsu_req_i` seen in `IDLE`, stall=1
  - C1: `dbus_req_o`=1
  - C2: `ack`=1, `dbus_req_o`=0, data captured at the C2 edge
  - C3: `lsu_done_o`=1
- **Latency:** 3 cycles request-to-done, plus extra wait cycles. Misaligned: done and misalign in C1.
- **Back-to-back:** a new request is accepted no earlier than the cycle after `DONE`.
- **Timeout:** `lsu_done_o` and `lsu_bus_err_o` fire `TIMEOUT_CYCLES`+1 cycles after entering `REQ`.

## Test plan
- **LW:** `addr` 0x100, responder word 0xDEADBEEF, 1-cycle ack.
  - `dbus_addr_o` 0x100, `sel_byte` 1111, `req` high exactly 1 cycle.
  - Done at C3, `lsu_rdata_o` 0xDEADBEEF.
- **Loads from word 0x80FF7F01 at 0x200:**
  - LB @0x203 → 0xFFFFFF80
  - LBU @0x203 → 0x00000080
  - LH @0x202 → 0xFFFF80FF
  - LHU @0x200 → 0x00007F01
- **Stores:**
  - SH `wdata` 0x1234ABCD @0x306 → `w_en`=1, `sel_byte` 1100, `w_data` 0xABCDABCD, `addr` 0x304, rdata 0.
  - SB @0x301 → `sel_byte` 0010.
- **Misaligned / illegal:**
  - LW @0x101 → `lsu_misalign_o`+`lsu_done_o` in C1, `dbus_req_o` never 1.
  - Store `op`=100 → same response.
- **Timeout:** `TIMEOUT_CYCLES`=4, no ack.
  - `req` held through the wait, then done+`bus_err`, rdata 0.
  - An ack injected 2 cycles later is ignored.
- **Reset:**
  - `rst_n` low during `REQ` → `dbus_req_o` 0 next cycle, no done pulse, all outputs 0.
  - A following LW completes normally.
